// File: rtl/sync_fifo_param.sv
// Parameterised single-clock FIFO with registered read data and occupancy flags.
// Define SYNC_FIFO_ERR_EN to add sticky overflow/underflow outputs.
module sync_fifo_param #(
   parameter int WIDTH    = 8,
   parameter int DEPTH    = 16,
   parameter int AF_LEVEL = DEPTH - 2,
   parameter int AE_LEVEL = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         din,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         dout,
   output logic                     rd_valid,
   output logic                     full,
   output logic                     empty,
   output logic                     almost_full,
   output logic                     almost_empty,
   output logic [$clog2(DEPTH):0]   count
`ifdef SYNC_FIFO_ERR_EN
   ,
   output logic                     overflow,
   output logic                     underflow
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
   localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

   logic [WIDTH-1:0] mem [DEPTH];

   logic [AW-1:0]    wr_ptr_reg, wr_ptr_next;
   logic [AW-1:0]    rd_ptr_reg, rd_ptr_next;
   logic [CW-1:0]    count_reg, count_next;
   logic [WIDTH-1:0] dout_reg;
   logic             rd_valid_reg;
   logic             wr_accept, rd_accept;

   // Flags come only from the registered count, never from this cycle's requests.
   assign full         = (count_reg == DEPTH_C);
   assign empty        = (count_reg == '0);
   assign almost_full  = (count_reg >= AF_C);
   assign almost_empty = (count_reg <= AE_C);
   assign count        = count_reg;
   assign dout         = dout_reg;
   assign rd_valid     = rd_valid_reg;

   assign wr_accept = wr_en && !full;
   assign rd_accept = rd_en && !empty;

   always_comb begin
      wr_ptr_next = wr_ptr_reg;
      rd_ptr_next = rd_ptr_reg;
      count_next  = count_reg;
      if (wr_accept) begin
         wr_ptr_next = wr_ptr_reg + 1'b1;
      end
      if (rd_accept) begin
         rd_ptr_next = rd_ptr_reg + 1'b1;
      end
      case ({wr_accept, rd_accept})
         2'b10:   count_next = count_reg + 1'b1;
         2'b01:   count_next = count_reg - 1'b1;
         default: count_next = count_reg;
      endcase
   end

   // Storage is left unreset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (wr_accept) begin
         mem[wr_ptr_reg] <= din;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
         dout_reg     <= '0;
         rd_valid_reg <= 1'b0;
      end else begin
         wr_ptr_reg   <= wr_ptr_next;
         rd_ptr_reg   <= rd_ptr_next;
         count_reg    <= count_next;
         rd_valid_reg <= rd_accept;
         if (rd_accept) begin
            dout_reg <= mem[rd_ptr_reg];
         end
      end
   end

`ifdef SYNC_FIFO_ERR_EN
   logic overflow_reg, underflow_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow_reg  <= 1'b0;
         underflow_reg <= 1'b0;
      end else begin
         if (wr_en && full) begin
            overflow_reg <= 1'b1;
         end
         if (rd_en && empty) begin
            underflow_reg <= 1'b1;
         end
      end
   end

   assign overflow  = overflow_reg;
   assign underflow = underflow_reg;
`endif

endmodule

// File: doc/sync_fifo_param.md
SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning data bits per entry (1..64).
REQ-002 The block SHALL have parameter DEPTH, default 16, meaning number of entries (power of two, 2..1024).
REQ-003 The block SHALL have parameter AF_LEVEL, default DEPTH-2, meaning the count at or above which almost_full asserts.
REQ-004 The block SHALL have parameter AE_LEVEL, default 2, meaning the count at or below which almost_empty asserts.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock, rising edge active.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-007 The block SHALL have port wr_en, input, 1 bit: write request.
REQ-008 The block SHALL have port din, input, WIDTH bits: write data.
REQ-009 The block SHALL have port rd_en, input, 1 bit: read request.
REQ-010 The block SHALL have port dout, output, WIDTH bits: read data, registered.
REQ-011 The block SHALL have port rd_valid, output, 1 bit: high for one cycle when dout carries newly read data.
REQ-012 The block SHALL have port full, output, 1 bit: asserted when count equals DEPTH.
REQ-013 The block SHALL have port empty, output, 1 bit: asserted when count equals 0.
REQ-014 The block SHALL have port almost_full, output, 1 bit: asserted when count >= AF_LEVEL.
REQ-015 The block SHALL have port almost_empty, output, 1 bit: asserted when count <= AE_LEVEL.
REQ-016 The block SHALL have port count, output, clog2(DEPTH)+1 bits: current occupancy, 0..DEPTH.

Function
REQ-017 A write SHALL be accepted iff wr_en=1 and full=0 at the rising edge; din is stored at wr_ptr, and wr_ptr advances modulo DEPTH.
REQ-018 A read SHALL be accepted iff rd_en=1 and empty=0 at the rising edge; mem[rd_ptr] is loaded into dout, rd_ptr advances modulo DEPTH, and rd_valid=1 on the following cycle.
REQ-019 Read latency SHALL be one cycle from the accepting edge to dout/rd_valid valid; dout SHALL hold its last value when no read is accepted.
REQ-020 count SHALL increment on an accepted write only, decrement on an accepted read only, and remain unchanged when both are accepted in the same cycle.
REQ-021 All flags SHALL be decoded from the registered count only, with no dependence on the current-cycle wr_en/rd_en.
REQ-022 When full: a write alone is dropped; a simultaneous read is accepted and the write is dropped; the next cycle full=0 and count=DEPTH-1.
REQ-023 When empty: a read alone is dropped with rd_valid=0; a simultaneous write is accepted and the read is dropped; the next cycle count=1.
REQ-024 Pointer wrap from DEPTH-1 to 0 SHALL be seamless, with no loss, duplication or reordering of data.
REQ-025 Data SHALL be read in strict write order (FIFO).

Reset
REQ-026 While rst=1: wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, rd_valid=0, dout=0.
REQ-027 Reset asserted mid-operation SHALL discard all stored data immediately; memory contents need not be cleared.
REQ-028 The first edge after rst deasserts SHALL accept requests normally.

Configuration
REQ-029 With macro SYNC_FIFO_ERR_EN defined, the block SHALL add 1-bit outputs overflow and underflow.
REQ-030 With SYNC_FIFO_ERR_EN defined, overflow SHALL set on a dropped write and underflow on a dropped read; both are sticky and cleared only by rst.
REQ-031 Without SYNC_FIFO_ERR_EN, these ports SHALL not exist, and dropped requests SHALL be silently ignored.

Verification (WIDTH=8, DEPTH=16, AF_LEVEL=14, AE_LEVEL=2)
REQ-032 Write 0x00..0x0F, then read 16 times -> dout=0x00..0x0F in order, each value one cycle after its read; full=1 after the 16th write; empty=1 after the 16th read.
REQ-033 When full, wr_en=1 with din=0xAA -> count stays 16 and 0xAA is never read; with SYNC_FIFO_ERR_EN, overflow=1 until rst.
REQ-034 When full, wr_en=1 and rd_en=1 together -> read returns the oldest entry, the write is dropped, and count=15.
REQ-035 When count=5, wr_en=1 and rd_en=1 together for 40 cycles -> count stays 5 throughout, pointers wrap at least twice, and the data order is intact.
REQ-036 Counting up from 0: almost_empty deasserts at count 3 and almost_full asserts at count 14; when empty, rd_en=1 -> rd_valid=0 (and underflow=1 when SYNC_FIFO_ERR_EN is defined).
REQ-037 Assert rst at count=9 in the middle of a read -> the same cycle shows count=0, empty=1 and rd_valid=0; after release, a write of 0x5A followed by a read returns 0x5A.
